// File: rtl/matrix_slot_manager.sv
// matrix_slot_manager: slot table for stored matrices.
// Answers slot queries with one-cycle registered latency. Serves allocation
// requests with a three-state FSM (IDLE, SEARCH, COMMIT) and serves free
// requests. Each slot owns a fixed-stride BRAM region.
// Optional feature macro: SLOT_OVERWRITE_EN. When it is defined, a full table
// recycles slots round-robin through a victim pointer instead of returning
// the "table full" error.
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 8
`endif

module matrix_slot_manager #(
  parameter int NUM_SLOTS  = 10,
  parameter int MAX_DIM    = 5,
  parameter int ADDR_WIDTH = `BRAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            config_max_dim,
  input  logic [3:0]            query_slot,
  output logic                  query_valid,
  output logic [3:0]            query_m,
  output logic [3:0]            query_n,
  output logic [ADDR_WIDTH-1:0] query_addr,
  output logic [7:0]            query_element_count,
  input  logic                  alloc_req,
  input  logic [3:0]            alloc_m,
  input  logic [3:0]            alloc_n,
  output logic                  alloc_ack,
  output logic [3:0]            alloc_slot,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic [1:0]            alloc_err,
  input  logic                  free_req,
  input  logic [3:0]            free_slot,
  output logic [7:0]            total_matrix_count
);

  localparam int         STRIDE   = MAX_DIM * MAX_DIM;
  localparam int         TBL      = 16;  // full 4-bit slot index space
  localparam logic [4:0] SLOTS_W  = 5'(NUM_SLOTS);
  localparam logic [3:0] LAST     = 4'(NUM_SLOTS - 1);
  localparam logic [3:0] MAXD_W   = 4'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

  state_t     state, state_nxt;
  logic       dim_phase, dim_phase_nxt;  // first SEARCH cycle checks dims
  logic [3:0] scan_idx, scan_nxt;
  logic [3:0] pick_slot, pick_nxt;
  logic [1:0] pick_err, err_nxt;
  logic [3:0] req_m, req_n;

  logic [TBL-1:0] slot_valid;
  logic [3:0]     slot_m   [TBL];
  logic [3:0]     slot_n   [TBL];
  logic [7:0]     slot_cnt [TBL];

  logic [3:0] dim_limit;
  logic       dim_bad;
  logic       commit_wr;
  logic       free_hit;
  logic       cnt_inc;

`ifdef SLOT_OVERWRITE_EN
  logic [3:0] victim, victim_nxt;
`endif

  assign dim_limit = (config_max_dim > MAXD_W) ? MAXD_W : config_max_dim;
  assign dim_bad   = (req_m == 4'd0) || (req_n == 4'd0) ||
                     (req_m > dim_limit) || (req_n > dim_limit);
  assign commit_wr = (state == COMMIT) && (pick_err == 2'd0);
  // A commit to the same slot in the same cycle overrides the free.
  assign free_hit  = free_req && ({1'b0, free_slot} < SLOTS_W) &&
                     slot_valid[free_slot] &&
                     !(commit_wr && (free_slot == pick_slot));
  assign cnt_inc   = commit_wr && !slot_valid[pick_slot];

  // Next-state and scan logic for the allocation FSM
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_nxt     = state;
    dim_phase_nxt = dim_phase;
    scan_nxt      = scan_idx;
    pick_nxt      = pick_slot;
    err_nxt       = pick_err;
`ifdef SLOT_OVERWRITE_EN
    victim_nxt    = victim;
`endif
    case (state)
      IDLE: begin
        if (alloc_req) begin
          state_nxt     = SEARCH;
          dim_phase_nxt = 1'b1;
          scan_nxt      = 4'd0;
        end
      end
      SEARCH: begin
        if (dim_phase) begin
          dim_phase_nxt = 1'b0;
          if (dim_bad) begin
            pick_nxt  = 4'd0;
            err_nxt   = 2'd1;
            state_nxt = COMMIT;
          end
        end else if (!slot_valid[scan_idx]) begin
          pick_nxt  = scan_idx;
          err_nxt   = 2'd0;
          state_nxt = COMMIT;
        end else if (scan_idx == LAST) begin
          state_nxt = COMMIT;
`ifdef SLOT_OVERWRITE_EN
          pick_nxt   = victim;
          err_nxt    = 2'd0;
          victim_nxt = (victim == LAST) ? 4'd0 : victim + 4'd1;
`else
          pick_nxt   = 4'd0;
          err_nxt    = 2'd2;
`endif
        end else begin
          scan_nxt = scan_idx + 4'd1;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register and latched request dimensions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dim_phase <= 1'b0;
      scan_idx  <= 4'd0;
      pick_slot <= 4'd0;
      pick_err  <= 2'd0;
      req_m     <= 4'd0;
      req_n     <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state     <= state_nxt;
      dim_phase <= dim_phase_nxt;
      scan_idx  <= scan_nxt;
      pick_slot <= pick_nxt;
      pick_err  <= err_nxt;
      if (state == IDLE && alloc_req) begin
        req_m <= alloc_m;
        req_n <= alloc_n;
      end
    end
  end

`ifdef SLOT_OVERWRITE_EN
  // Round-robin victim pointer used when the table is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) victim <= 4'd0;
    else        victim <= victim_nxt;
  end
`endif

  // Valid bits and occupancy count; commit and free may land in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid         <= '0;
      total_matrix_count <= 8'd0;
    end else begin
      if (free_hit)  slot_valid[free_slot] <= 1'b0;
      if (commit_wr) slot_valid[pick_slot] <= 1'b1;
      if (cnt_inc && !free_hit)      total_matrix_count <= total_matrix_count + 8'd1;
      else if (!cnt_inc && free_hit) total_matrix_count <= total_matrix_count - 8'd1;
    end
  end

  // Slot payload, written on a successful commit
  // NOTE: payload is not reset; query outputs are masked by the reset valid bits.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      slot_m[pick_slot]   <= req_m;
      slot_n[pick_slot]   <= req_n;
      slot_cnt[pick_slot] <= {4'd0, req_m} * {4'd0, req_n};
    end
  end

  // Allocation response, registered on the COMMIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ack  <= 1'b0;
      alloc_slot <= 4'd0;
      alloc_addr <= '0;
      alloc_err  <= 2'd0;
    end else begin
      alloc_ack <= (state == COMMIT);
      if (state == COMMIT) begin
        alloc_slot <= pick_slot;
        alloc_addr <= ADDR_WIDTH'(pick_slot) * ADDR_WIDTH'(STRIDE);
        alloc_err  <= pick_err;
      end
    end
  end

  // Registered query lookup from the pre-edge table contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_valid         <= 1'b0;
      query_m             <= 4'd0;
      query_n             <= 4'd0;
      query_addr          <= '0;
      query_element_count <= 8'd0;
    end else if (({1'b0, query_slot} < SLOTS_W) && slot_valid[query_slot]) begin
      query_valid         <= 1'b1;
      query_m             <= slot_m[query_slot];
      query_n             <= slot_n[query_slot];
      query_addr          <= ADDR_WIDTH'(query_slot) * ADDR_WIDTH'(STRIDE);
      query_element_count <= slot_cnt[query_slot];
    end else begin
      query_valid         <= 1'b0;
      query_m             <= 4'd0;
      query_n             <= 4'd0;
      query_addr          <= '0;
      query_element_count <= 8'd0;
    end
  end

endmodule
